// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid constants, FSM state encoding and way codes for the snake pipeline
package snake_pkg;

  // Logical playfield
  localparam int H_LOGIC_MAX   = 31;
  localparam int V_LOGIC_MAX   = 23;
  localparam int H_LOGIC_WIDTH = 5;
  localparam int V_LOGIC_WIDTH = 5;

  // Snake length saturation value
  localparam int LEN_MAX = 199;

  // Way codes used by the movement stage
  localparam logic [1:0] WAY_UP    = 2'd0;
  localparam logic [1:0] WAY_DOWN  = 2'd1;
  localparam logic [1:0] WAY_LEFT  = 2'd2;
  localparam logic [1:0] WAY_RIGHT = 2'd3;

  // Collision / growth evaluation states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEAD     = 3'd1,
    ST_SCAN     = 3'd2,
    ST_RESOLVE  = 3'd3,
    ST_RELOCATE = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

endpackage

// File: rtl/food_lfsr.sv
// rtl/food_lfsr.sv - free-running 16-bit LFSR folded onto the grid as a food candidate
module food_lfsr
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [H_LOGIC_WIDTH-1:0] cand_x,
  output logic [V_LOGIC_WIDTH-1:0] cand_y
);

  logic [15:0]              lfsr;
  logic                     feedback;
  logic [H_LOGIC_WIDTH:0]   raw_x;
  logic [V_LOGIC_WIDTH:0]   raw_y;
  logic [H_LOGIC_WIDTH:0]   wrap_x;
  logic [V_LOGIC_WIDTH:0]   wrap_y;

  // Fibonacci taps 16,14,13,11 (bit 15 is tap 16)
  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // LFSR steps on every cycle outside reset so retries see a fresh value
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

  // Raw fields are widened by one bit so the range test is not a constant compare
  assign raw_x  = {1'b0, lfsr[H_LOGIC_WIDTH-1:0]};
  assign raw_y  = {1'b0, lfsr[H_LOGIC_WIDTH +: V_LOGIC_WIDTH]};
  assign wrap_x = raw_x - (H_LOGIC_WIDTH+1)'(H_LOGIC_MAX + 1);
  assign wrap_y = raw_y - (V_LOGIC_WIDTH+1)'(V_LOGIC_MAX + 1);

  // Fold out-of-range fields back onto the grid with a single subtraction
  always_comb begin
    cand_x = raw_x[H_LOGIC_WIDTH-1:0];
    cand_y = raw_y[V_LOGIC_WIDTH-1:0];
    if (raw_x > (H_LOGIC_WIDTH+1)'(H_LOGIC_MAX)) begin
      cand_x = wrap_x[H_LOGIC_WIDTH-1:0];
    end
    if (raw_y > (V_LOGIC_WIDTH+1)'(V_LOGIC_MAX)) begin
      cand_y = wrap_y[V_LOGIC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/snake_collide_grow.sv
// rtl/snake_collide_grow.sv - head/body collision, food eating, growth, score and food relocation
module snake_collide_grow
  import snake_pkg::*;
#(
  parameter int          INIT_LEN  = 3,
  parameter int          FOOD_X0   = 10,
  parameter int          FOOD_Y0   = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     DLY_RST,
  input  logic                     vld,
  input  logic                     seg_valid,
  input  logic [H_LOGIC_WIDTH-1:0] seg_x,
  input  logic [V_LOGIC_WIDTH-1:0] seg_y,
  input  logic                     seg_is_end,
  output logic                     seg_req,
  output logic [9:0]               length,
  output logic [H_LOGIC_WIDTH-1:0] food_x,
  output logic [V_LOGIC_WIDTH-1:0] food_y,
  output logic                     eaten,
  output logic [9:0]               score,
  output logic                     game_over
);

  state_t                     state;
  state_t                     next_state;
  logic [H_LOGIC_WIDTH-1:0]   head_x;
  logic [V_LOGIC_WIDTH-1:0]   head_y;
  logic                       eat_flag;
  logic                       hit_flag;
  logic [H_LOGIC_WIDTH-1:0]   cand_x;
  logic [V_LOGIC_WIDTH-1:0]   cand_y;
  logic                       seg_on_head;
  logic                       seg_on_food;
  logic                       cand_on_head;

  food_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_food_lfsr (
    .clk    (clk),
    .rst    (DLY_RST),
    .cand_x (cand_x),
    .cand_y (cand_y)
  );

  assign seg_on_head  = (seg_x == head_x) && (seg_y == head_y);
  assign seg_on_food  = (seg_x == food_x) && (seg_y == food_y);
  assign cand_on_head = (cand_x == head_x) && (cand_y == head_y);

  // State register
  always_ff @(posedge clk) begin
    if (DLY_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a move tick during streaming restarts at the head beat
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (vld) next_state = ST_HEAD;
      end
      ST_HEAD: begin
        if (vld) begin
          next_state = ST_HEAD;
        end else if (seg_valid) begin
          next_state = seg_is_end ? ST_RESOLVE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (vld) begin
          next_state = ST_HEAD;
        end else if (seg_valid && seg_is_end) begin
          next_state = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (hit_flag) begin
          next_state = ST_OVER;
        end else if (eat_flag) begin
          next_state = ST_RELOCATE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RELOCATE: begin
        if (!cand_on_head) next_state = ST_IDLE;
      end
      ST_OVER: begin
        next_state = ST_OVER;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; eaten fires only in the resolving cycle without a hit
  always_comb begin
    seg_req = 1'b0;
    eaten   = 1'b0;
    case (state)
      ST_HEAD, ST_SCAN: seg_req = 1'b1;
      ST_RESOLVE:       eaten   = eat_flag && !hit_flag;
      default: begin
        seg_req = 1'b0;
        eaten   = 1'b0;
      end
    endcase
  end

  // Round datapath: latch head, accumulate flags, then commit growth, score and food
  always_ff @(posedge clk) begin
    if (DLY_RST) begin
      head_x    <= '0;
      head_y    <= '0;
      eat_flag  <= 1'b0;
      hit_flag  <= 1'b0;
      length    <= 10'(INIT_LEN);
      score     <= '0;
      food_x    <= H_LOGIC_WIDTH'(FOOD_X0);
      food_y    <= V_LOGIC_WIDTH'(FOOD_Y0);
      game_over <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vld) begin
            eat_flag <= 1'b0;
            hit_flag <= 1'b0;
          end
        end
        ST_HEAD: begin
          if (vld) begin
            eat_flag <= 1'b0;
            hit_flag <= 1'b0;
          end else if (seg_valid) begin
            head_x   <= seg_x;
            head_y   <= seg_y;
            eat_flag <= seg_on_food;
          end
        end
        ST_SCAN: begin
          if (vld) begin
            eat_flag <= 1'b0;
            hit_flag <= 1'b0;
          end else if (seg_valid && seg_on_head) begin
            hit_flag <= 1'b1;
          end
        end
        ST_RESOLVE: begin
          if (hit_flag) begin
            game_over <= 1'b1;
          end else if (eat_flag) begin
            if (length < 10'(LEN_MAX)) length <= length + 10'd1;
            if (score != 10'h3FF)      score  <= score + 10'd1;
          end
        end
        ST_RELOCATE: begin
          if (!cand_on_head) begin
            food_x <= cand_x;
            food_y <= cand_y;
          end
        end
        default: begin
          game_over <= game_over;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_collide_grow.sv
// tb/tb_snake_collide_grow.sv - randomized self-checking bench against a round-level game model
module tb_snake_collide_grow;
  import snake_pkg::*;

  logic                     clk = 1'b0;
  logic                     DLY_RST;
  logic                     vld;
  logic                     seg_valid;
  logic [H_LOGIC_WIDTH-1:0] seg_x;
  logic [V_LOGIC_WIDTH-1:0] seg_y;
  logic                     seg_is_end;
  logic                     seg_req;
  logic [9:0]               length;
  logic [H_LOGIC_WIDTH-1:0] food_x;
  logic [V_LOGIC_WIDTH-1:0] food_y;
  logic                     eaten;
  logic [9:0]               score;
  logic                     game_over;

  always #5 clk = ~clk;

  snake_collide_grow dut (
    .clk        (clk),
    .DLY_RST    (DLY_RST),
    .vld        (vld),
    .seg_valid  (seg_valid),
    .seg_x      (seg_x),
    .seg_y      (seg_y),
    .seg_is_end (seg_is_end),
    .seg_req    (seg_req),
    .length     (length),
    .food_x     (food_x),
    .food_y     (food_y),
    .eaten      (eaten),
    .score      (score),
    .game_over  (game_over)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Game model
  int m_len, m_score, m_fx, m_fy;
  bit m_over;
  int bx[4];
  int by[4];

  // Reference LFSR: value seen by the design in the current cycle
  logic [15:0] m_lfsr;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[14:0], fb};
  endfunction
  always @(posedge clk) begin
    if (DLY_RST) m_lfsr <= 16'hACE1;
    else         m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic do_reset();
    DLY_RST = 1'b1; vld = 1'b0; seg_valid = 1'b0; seg_x = '0; seg_y = '0; seg_is_end = 1'b0;
    repeat (3) @(negedge clk);
    DLY_RST = 1'b0;
    m_len = 3; m_score = 0; m_fx = 10; m_fy = 12; m_over = 0;
  endtask

  task automatic send_beat(input int x, input int y, input bit last, input bit gaps, input string tag);
    if (gaps && $urandom_range(0, 2) == 0) begin
      seg_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (seg_req !== !m_over) begin
        n_err++;
        $display("FAIL %s seg_req_gap got=%0b want=%0b", tag, seg_req, !m_over);
      end
    end
    seg_valid = 1'b1; seg_x = 5'(x); seg_y = 5'(y); seg_is_end = last;
    @(negedge clk);
    seg_valid = 1'b0; seg_is_end = 1'b0;
  endtask

  // One move tick: head then nb body beats from bx/by; optional decoy round aborted by a second tick
  task automatic run_round(input int hx, input int hy, input int nb, input bit gaps, input bit restart, input string tag);
    bit exp_eat, exp_hit;
    int cx, cy, tries;
    exp_eat = (hx == m_fx) && (hy == m_fy);
    exp_hit = 0;
    for (int k = 0; k < nb; k++) if (bx[k] == hx && by[k] == hy) exp_hit = 1;

    @(negedge clk); vld = 1'b1;
    @(negedge clk); vld = 1'b0;
    n_cmp++;
    if (seg_req !== !m_over) begin
      n_err++;
      $display("FAIL %s seg_req_after_vld got=%0b want=%0b", tag, seg_req, !m_over);
    end
    if (restart) begin
      send_beat((m_fx + 1) % 32, hy, 1'b0, 1'b0, tag);
      send_beat(2, 2, 1'b0, 1'b0, tag);
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
    end
    send_beat(hx, hy, nb == 0, gaps, tag);
    for (int k = 0; k < nb; k++) send_beat(bx[k], by[k], k == nb - 1, gaps, tag);

    n_cmp++;
    if (eaten !== (!m_over && exp_eat && !exp_hit)) begin
      n_err++;
      $display("FAIL %s eaten_resolve got=%0b want=%0b", tag, eaten, !m_over && exp_eat && !exp_hit);
    end
    n_cmp++;
    if (seg_req !== 1'b0) begin
      n_err++;
      $display("FAIL %s seg_req_resolve got=%0b want=0", tag, seg_req);
    end

    if (m_over) begin
      @(negedge clk);
    end else if (exp_hit) begin
      m_over = 1;
      @(negedge clk);
    end else if (exp_eat) begin
      m_len   = (m_len + 1 > LEN_MAX) ? LEN_MAX : m_len + 1;
      m_score = (m_score + 1 > 1023) ? 1023 : m_score + 1;
      @(negedge clk);
      n_cmp++;
      if (eaten !== 1'b0) begin
        n_err++;
        $display("FAIL %s eaten_width got=%0b want=0", tag, eaten);
      end
      tries = 0;
      forever begin
        cx = int'(m_lfsr[4:0]) % (H_LOGIC_MAX + 1);
        cy = int'(m_lfsr[9:5]) % (V_LOGIC_MAX + 1);
        if (cx != hx || cy != hy) break;
        tries++;
        if (tries > 64) break;
        @(negedge clk);
      end
      n_cmp++;
      if (tries > 64) begin
        n_err++;
        $display("FAIL %s relocate_bound got=%0d want<=64", tag, tries);
      end
      m_fx = cx; m_fy = cy;
      @(negedge clk);
      n_cmp++;
      if (food_x !== 5'(m_fx) || food_y !== 5'(m_fy) || (food_x == 5'(hx) && food_y == 5'(hy))) begin
        n_err++;
        $display("FAIL %s food got=(%0d,%0d) want=(%0d,%0d)", tag, food_x, food_y, m_fx, m_fy);
      end
    end else begin
      @(negedge clk);
    end

    n_cmp++;
    if (length !== 10'(m_len) || score !== 10'(m_score)) begin
      n_err++;
      $display("FAIL %s len_score got=%0d/%0d want=%0d/%0d", tag, length, score, m_len, m_score);
    end
    n_cmp++;
    if (game_over !== m_over || eaten !== 1'b0 || seg_req !== 1'b0) begin
      n_err++;
      $display("FAIL %s end_state got=go%0b/e%0b/r%0b want=go%0b/e0/r0", tag, game_over, eaten, seg_req, m_over);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (length !== 10'd3 || food_x !== 5'd10 || food_y !== 5'd12 || score !== 10'd0
        || game_over !== 1'b0 || seg_req !== 1'b0 || eaten !== 1'b0) begin
      n_err++;
      $display("FAIL reset got=len%0d food(%0d,%0d) sc%0d go%0b req%0b e%0b want=len3 food(10,12) sc0 go0 req0 e0",
               length, food_x, food_y, score, game_over, seg_req, eaten);
    end
  endtask

  task automatic test_no_event();
    bx[0] = 4; by[0] = 5; bx[1] = 3; by[1] = 5;
    run_round(5, 5, 2, 1'b0, 1'b0, "no_event");
  endtask

  task automatic test_eat();
    bx[0] = 9; by[0] = 12; bx[1] = 8; by[1] = 12;
    run_round(10, 12, 2, 1'b0, 1'b0, "eat");
    n_cmp++;
    if (length !== 10'd4 || score !== 10'd1) begin
      n_err++;
      $display("FAIL eat_const got=%0d/%0d want=4/1", length, score);
    end
  endtask

  task automatic test_random();
    int hx, hy, nb;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        hx = m_fx; hy = m_fy;
      end else begin
        hx = $urandom_range(0, 31); hy = $urandom_range(0, 23);
      end
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++) begin
        bx[k] = $urandom_range(0, 31); by[k] = $urandom_range(0, 23);
        if (bx[k] == hx && by[k] == hy) bx[k] = (hx + 1) % 32;
      end
      run_round(hx, hy, nb, 1'b1, 1'b0, "random");
    end
  endtask

  task automatic test_restart();
    bx[0] = (m_fx + 3) % 32; by[0] = m_fy;
    run_round(m_fx, m_fy, 1, 1'b0, 1'b1, "restart");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 202; r++) begin
      bx[0] = (m_fx + 1) % 32; by[0] = m_fy;
      run_round(m_fx, m_fy, 1, 1'b0, 1'b0, "saturation");
    end
    n_cmp++;
    if (length !== 10'd199 || score !== 10'd202) begin
      n_err++;
      $display("FAIL saturation_const got=%0d/%0d want=199/202", length, score);
    end
  endtask

  task automatic test_hit_and_eat();
    do_reset();
    bx[0] = 10; by[0] = 12;
    run_round(10, 12, 1, 1'b0, 1'b0, "hit_and_eat");
    n_cmp++;
    if (game_over !== 1'b1 || length !== 10'd3 || score !== 10'd0) begin
      n_err++;
      $display("FAIL hit_and_eat_const got=go%0b len%0d sc%0d want=go1 len3 sc0", game_over, length, score);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bx[0] = 7; by[0] = 8; bx[1] = 7; by[1] = 7;
    run_round(7, 7, 2, 1'b0, 1'b0, "collision");
    bx[0] = 2; by[0] = 3;
    run_round(3, 3, 1, 1'b1, 1'b0, "over_frozen");
    bx[0] = 9; by[0] = 12;
    run_round(10, 12, 1, 1'b0, 1'b0, "over_food");
    n_cmp++;
    if (game_over !== 1'b1 || length !== 10'd3 || score !== 10'd0) begin
      n_err++;
      $display("FAIL over_sticky got=go%0b len%0d sc%0d want=go1 len3 sc0", game_over, length, score);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (game_over !== 1'b0 || length !== 10'd3) begin
      n_err++;
      $display("FAIL over_reset got=go%0b len%0d want=go0 len3", game_over, length);
    end
  endtask

  initial begin
    test_reset();
    test_no_event();
    test_eat();
    test_random();
    test_restart();
    test_saturation();
    test_hit_and_eat();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
